// File: rtl/mac_tx_framegen_if.sv
// Logic-side TX byte stream from the frame generator into the RGMII MAC.
// The MAC adds the preamble, SFD and FCS.
interface mac_tx_framegen_if;
  logic [7:0] mac_tx_data;
  logic       mac_tx_valid;
  logic       mac_tx_sof;
  logic       mac_tx_eof;

  modport master (
    output mac_tx_data,
    output mac_tx_valid,
    output mac_tx_sof,
    output mac_tx_eof
  );

  modport slave (
    input mac_tx_data,
    input mac_tx_valid,
    input mac_tx_sof,
    input mac_tx_eof
  );
endinterface

// File: rtl/mac_tx_framegen.sv
// Test-frame generator: emits DST/SRC/EtherType, a 32-bit sequence number and a
// counting payload on the MAC TX byte stream, with a programmable inter-frame gap.
module mac_tx_framegen #(
  parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC   = 48'h0200_0000_0001,
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter int unsigned MIN_IFG   = 12
) (
  input  logic                     mac_tx_clk,
  input  logic                     areset_n,
  input  logic                     start,
  input  logic                     cont_en,
  input  logic [10:0]              frame_len,
  input  logic [15:0]              ifg_len,
  mac_tx_framegen_if.master        tx,
  output logic                     busy,
  output logic                     frame_done,
  output logic [31:0]              frame_cnt
);

  localparam logic [10:0] LEN_MIN = 11'd60;
  localparam logic [10:0] LEN_MAX = 11'd1514;
  localparam logic [15:0] IFG_MIN = 16'(MIN_IFG);
  localparam logic [10:0] HDR_LEN = 11'd18;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [10:0] len_q, len_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [15:0] gap_len_q, gap_len_d;
  logic [31:0] seq_q, seq_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        launch;

  function automatic logic [10:0] clamp_len(input logic [10:0] n);
    logic [10:0] r;
    if (n < LEN_MIN)      r = LEN_MIN;
    else if (n > LEN_MAX) r = LEN_MAX;
    else                  r = n;
    return r;
  endfunction

  function automatic logic [15:0] clamp_ifg(input logic [15:0] n);
    return (n < IFG_MIN) ? IFG_MIN : n;
  endfunction

  // Header bytes come from one 18-byte vector shifted down; beyond it the
  // payload counts up from the low byte of the sequence number.
  function automatic logic [7:0] frame_byte(input logic [10:0] k, input logic [31:0] seq);
    logic [143:0] hdr;
    logic [143:0] sh;
    logic [7:0]   b;
    hdr = {DST_MAC, SRC_MAC, ETHERTYPE, seq};
    sh  = '0;
    if (k < HDR_LEN) begin
      sh = hdr >> {(11'd17 - k), 3'b000};
      b  = sh[7:0];
    end else begin
      b = seq[7:0] + k[7:0] - 8'd18;
    end
    return b;
  endfunction

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    len_d       = len_q;
    gap_cnt_d   = gap_cnt_q;
    gap_len_d   = gap_len_q;
    seq_d       = seq_q;
    frame_cnt_d = frame_cnt_q;
    data_d      = 8'h00;
    valid_d     = 1'b0;
    sof_d       = 1'b0;
    eof_d       = 1'b0;
    done_d      = 1'b0;
    launch      = 1'b0;

    unique case (state_q)
      IDLE: launch = start | cont_en;

      FRAME: begin
        if (byte_cnt_q == len_q - 11'd1) begin
          state_d     = GAP;
          gap_cnt_d   = 16'd1;
          frame_cnt_d = frame_cnt_q + 32'd1;
          done_d      = 1'b1;
        end else begin
          byte_cnt_d = byte_cnt_q + 11'd1;
          data_d     = frame_byte(byte_cnt_d, seq_q);
          valid_d    = 1'b1;
          eof_d      = (byte_cnt_d == len_q - 11'd1);
        end
      end

      // gap_cnt_q numbers the idle cycle currently on the wire, 1..G
      GAP: begin
        if (gap_cnt_q == gap_len_q) begin
          if (cont_en) launch = 1'b1;
          else         state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Frame parameters are captured here so later input changes only affect the next frame.
    if (launch) begin
      state_d    = FRAME;
      byte_cnt_d = 11'd0;
      len_d      = clamp_len(frame_len);
      gap_len_d  = clamp_ifg(ifg_len);
      seq_d      = frame_cnt_q;
      data_d     = frame_byte(11'd0, frame_cnt_q);
      valid_d    = 1'b1;
      sof_d      = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge mac_tx_clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      len_q       <= LEN_MIN;
      gap_cnt_q   <= '0;
      gap_len_q   <= IFG_MIN;
      seq_q       <= '0;
      frame_cnt_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      len_q       <= len_d;
      gap_cnt_q   <= gap_cnt_d;
      gap_len_q   <= gap_len_d;
      seq_q       <= seq_d;
      frame_cnt_q <= frame_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign tx.mac_tx_data  = data_q;
  assign tx.mac_tx_valid = valid_q;
  assign tx.mac_tx_sof   = sof_q;
  assign tx.mac_tx_eof   = eof_q;
  assign busy            = busy_q;
  assign frame_done      = done_q;
  assign frame_cnt       = frame_cnt_q;

endmodule

// File: tb/tb_mac_tx_framegen.sv
// Bench for mac_tx_framegen: a negedge monitor splits the TX stream into frames,
// and each scenario compares them with frames rebuilt from the frame format rules.
module tb_mac_tx_framegen;

  logic        clk;
  logic        areset_n;
  logic        start;
  logic        cont_en;
  logic [10:0] frame_len;
  logic [15:0] ifg_len;
  logic        busy;
  logic        frame_done;
  logic [31:0] frame_cnt;

  mac_tx_framegen_if tx();

  mac_tx_framegen dut (
    .mac_tx_clk (clk),
    .areset_n   (areset_n),
    .start      (start),
    .cont_en    (cont_en),
    .frame_len  (frame_len),
    .ifg_len    (ifg_len),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  int n_tests;
  int n_fail;

  localparam logic [7:0] HDR [14] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                      8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                                      8'h88, 8'hB5};

  // Monitor state: all bytes in arrival order plus per-frame bookkeeping.
  int         cyc;
  logic [7:0] mb[$];
  int         f_start[$];
  int         f_len[$];
  int         f_sof[$];
  int         f_eof[$];
  int         done_cyc[$];
  int         mon_err;
  int         sof_count;
  int         busy_fall;
  logic       busy_prev;
  logic       in_frame;
  int         cur_start;
  int         cur_sof;

  initial begin
    cyc = 0; mon_err = 0; sof_count = 0; busy_fall = -1;
    busy_prev = 1'b0; in_frame = 1'b0; cur_start = 0; cur_sof = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!areset_n) begin
        in_frame  = 1'b0;
        busy_prev = 1'b0;
      end else begin
        if (frame_done) done_cyc.push_back(cyc);
        if (busy_prev && !busy) busy_fall = cyc;
        busy_prev = busy;
        if (tx.mac_tx_valid) begin
          if (tx.mac_tx_sof) begin
            if (in_frame) mon_err++;
            in_frame  = 1'b1;
            cur_start = mb.size();
            cur_sof   = cyc;
            sof_count++;
          end else if (!in_frame) begin
            mon_err++;
          end
          if (in_frame) begin
            mb.push_back(tx.mac_tx_data);
            if (tx.mac_tx_eof) begin
              if (tx.mac_tx_sof) mon_err++;
              f_start.push_back(cur_start);
              f_len.push_back(mb.size() - cur_start);
              f_sof.push_back(cur_sof);
              f_eof.push_back(cyc);
              in_frame = 1'b0;
            end
          end
        end else begin
          if (in_frame) mon_err++;
          if (tx.mac_tx_sof || tx.mac_tx_eof || tx.mac_tx_data != 8'h00) mon_err++;
        end
      end
    end
  end

  initial begin
    #700000;
    $display("FAIL watchdog: simulation still running at %0t, limit 700000", $time);
    $fatal(1, "watchdog expired");
  end

  // Reference model of the frame format.
  function automatic int exp_len(int fl);
    if (fl < 60) return 60;
    if (fl > 1514) return 1514;
    return fl;
  endfunction

  function automatic int exp_gap(int g);
    return (g < 12) ? 12 : g;
  endfunction

  function automatic logic [7:0] exp_byte(int k, logic [31:0] seq);
    if (k < 14) return HDR[k];
    if (k < 18) return 8'(seq >> (8 * (17 - k)));
    return 8'((int'(seq[7:0]) + k - 18) % 256);
  endfunction

  function automatic int frame_errs(int fi, int len, logic [31:0] seq);
    int e;
    e = 0;
    if (fi >= f_len.size()) return len;
    for (int k = 0; k < len && k < f_len[fi]; k++)
      if (mb[f_start[fi] + k] !== exp_byte(k, seq)) e++;
    return e;
  endfunction

  task automatic clear_mon();
    mb.delete(); f_start.delete(); f_len.delete(); f_sof.delete(); f_eof.delete();
    done_cyc.delete();
    mon_err = 0; sof_count = 0; busy_fall = -1;
  endtask

  task automatic do_reset();
    start = 1'b0; cont_en = 1'b0;
    areset_n = 1'b0;
    repeat (2) @(negedge clk);
    areset_n = 1'b1;
    @(negedge clk);
    clear_mon();
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (f_len.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_sofs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sof_count >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    start = 1'b0; cont_en = 1'b0; frame_len = 11'd64; ifg_len = 16'd0;
    #1 areset_n = 1'b1;
    #5 areset_n = 1'b0;
    #1;
    n_tests++; if (tx.mac_tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", tx.mac_tx_valid); end
    n_tests++; if (tx.mac_tx_sof !== 1'b0 || tx.mac_tx_eof !== 1'b0) begin n_fail++; $display("FAIL reset_sof_eof: got %b%b want 00", tx.mac_tx_sof, tx.mac_tx_eof); end
    n_tests++; if (tx.mac_tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", tx.mac_tx_data); end
    n_tests++; if (busy !== 1'b0 || frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b%b want 00", busy, frame_done); end
    n_tests++; if (frame_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %h want 0", frame_cnt); end
    repeat (2) @(negedge clk);
    areset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (busy !== 1'b0 || tx.mac_tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_after_release: busy %b valid %b want 0 0", busy, tx.mac_tx_valid); end
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    frame_len = 11'd64; ifg_len = 16'd0;
    pulse_start();
    n_tests++; if (tx.mac_tx_sof !== 1'b1 || tx.mac_tx_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: sof %b valid %b want 1 1", tx.mac_tx_sof, tx.mac_tx_valid); end
    wait_frames(1, 200, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_timeout: frames %0d want 1", f_len.size()); end
    wait_idle(100, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_idle_timeout: busy %b want 0", busy); end
    if (f_len.size() >= 1) begin
      n_tests++; if (f_len[0] !== 64) begin n_fail++; $display("FAIL single_len: got %0d want 64", f_len[0]); end
      n_tests++; if (frame_errs(0, 64, 32'd0) !== 0) begin n_fail++; $display("FAIL single_bytes: %0d bad bytes want 0", frame_errs(0, 64, 32'd0)); end
      n_tests++; if (mb[f_start[0] + 63] !== 8'h2D) begin n_fail++; $display("FAIL single_last_payload: got %h want 2d", mb[f_start[0] + 63]); end
      n_tests++; if (done_cyc.size() !== 1 || done_cyc[0] !== f_eof[0] + 1) begin n_fail++; $display("FAIL single_done: pulses %0d want 1 at eof+1", done_cyc.size()); end
      n_tests++; if (busy_fall !== f_eof[0] + 13) begin n_fail++; $display("FAIL single_gap: busy fell at %0d want %0d", busy_fall, f_eof[0] + 13); end
    end
    n_tests++; if (frame_cnt !== 32'd1) begin n_fail++; $display("FAIL single_frame_cnt: got %0d want 1", frame_cnt); end
    repeat (30) @(negedge clk);
    n_tests++; if (f_len.size() !== 1 || mon_err !== 0) begin n_fail++; $display("FAIL single_quiet: frames %0d proto_err %0d want 1 0", f_len.size(), mon_err); end
  endtask

  task automatic test_cont();
    bit ok;
    do_reset();
    frame_len = 11'd100; ifg_len = 16'd20; cont_en = 1'b1;
    wait_sofs(3, 1000, ok);
    cont_en = 1'b0;
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL cont_sof_timeout: sofs %0d want 3", sof_count); end
    wait_frames(3, 500, ok);
    wait_idle(100, ok);
    n_tests++; if (f_len.size() !== 3) begin n_fail++; $display("FAIL cont_frames: got %0d want 3", f_len.size()); end
    for (int i = 0; i < f_len.size() && i < 3; i++) begin
      n_tests++; if (f_len[i] !== 100 || frame_errs(i, 100, 32'(i)) !== 0) begin n_fail++; $display("FAIL cont_frame%0d: len %0d bad %0d want 100 0", i, f_len[i], frame_errs(i, 100, 32'(i))); end
      if (i > 0) begin
        n_tests++; if (f_sof[i] - f_eof[i-1] - 1 !== 20) begin n_fail++; $display("FAIL cont_gap%0d: got %0d want 20", i, f_sof[i] - f_eof[i-1] - 1); end
      end
    end
    if (f_len.size() == 3) begin
      n_tests++; if (mb[f_start[2] + 18] !== 8'h02) begin n_fail++; $display("FAIL cont_payload2: got %h want 02", mb[f_start[2] + 18]); end
      n_tests++; if (busy_fall !== f_eof[2] + 21) begin n_fail++; $display("FAIL cont_last_gap: busy fell %0d want %0d", busy_fall, f_eof[2] + 21); end
    end
    n_tests++; if (frame_cnt !== 32'd3 || mon_err !== 0) begin n_fail++; $display("FAIL cont_cnt: cnt %0d proto_err %0d want 3 0", frame_cnt, mon_err); end
  endtask

  task automatic test_clamp();
    bit ok;
    do_reset();
    frame_len = 11'd10; ifg_len = 16'd0;
    pulse_start();
    wait_frames(1, 200, ok);
    wait_idle(100, ok);
    frame_len = 11'd2000;
    pulse_start();
    wait_frames(2, 3000, ok);
    wait_idle(100, ok);
    n_tests++; if (f_len.size() !== 2) begin n_fail++; $display("FAIL clamp_frames: got %0d want 2", f_len.size()); end
    if (f_len.size() == 2) begin
      n_tests++; if (f_len[0] !== 60 || frame_errs(0, 60, 32'd0) !== 0) begin n_fail++; $display("FAIL clamp_short: len %0d want 60", f_len[0]); end
      n_tests++; if (f_len[1] !== 1514 || frame_errs(1, 1514, 32'd1) !== 0) begin n_fail++; $display("FAIL clamp_long: len %0d want 1514", f_len[1]); end
      n_tests++; if (mb[f_start[1] + f_len[1] - 1] !== 8'((1 + 1495) % 256)) begin n_fail++; $display("FAIL clamp_last_byte: got %h want %h", mb[f_start[1] + f_len[1] - 1], 8'((1 + 1495) % 256)); end
    end
    n_tests++; if (frame_cnt !== 32'd2 || mon_err !== 0) begin n_fail++; $display("FAIL clamp_cnt: cnt %0d proto_err %0d want 2 0", frame_cnt, mon_err); end
  endtask

  task automatic test_start_ignored();
    bit ok;
    do_reset();
    frame_len = 11'd64; ifg_len = 16'd0;
    pulse_start();
    repeat (10) @(negedge clk);
    pulse_start();
    wait_frames(1, 200, ok);
    repeat (3) @(negedge clk);
    n_tests++; if (busy !== 1'b1 || tx.mac_tx_valid !== 1'b0) begin n_fail++; $display("FAIL ignore_in_gap: busy %b valid %b want 1 0", busy, tx.mac_tx_valid); end
    pulse_start();
    wait_idle(100, ok);
    repeat (40) @(negedge clk);
    n_tests++; if (f_len.size() !== 1 || sof_count !== 1) begin n_fail++; $display("FAIL ignore_frames: frames %0d sofs %0d want 1 1", f_len.size(), sof_count); end
    n_tests++; if (frame_cnt !== 32'd1) begin n_fail++; $display("FAIL ignore_cnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    frame_len = 11'd64; ifg_len = 16'd0;
    pulse_start();
    repeat (30) @(negedge clk);
    #1 areset_n = 1'b0;
    #1;
    n_tests++; if (tx.mac_tx_valid !== 1'b0 || tx.mac_tx_sof !== 1'b0 || tx.mac_tx_eof !== 1'b0) begin n_fail++; $display("FAIL areset_outputs: v/s/e %b%b%b want 000", tx.mac_tx_valid, tx.mac_tx_sof, tx.mac_tx_eof); end
    n_tests++; if (frame_cnt !== 32'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL areset_cnt: cnt %0d busy %b want 0 0", frame_cnt, busy); end
    repeat (2) @(negedge clk);
    areset_n = 1'b1;
    n_tests++; if (f_len.size() !== 0) begin n_fail++; $display("FAIL areset_no_eof: frames %0d want 0", f_len.size()); end
    cont_en = 1'b1;
    wait_sofs(2, 100, ok);
    cont_en = 1'b0;
    wait_frames(1, 200, ok);
    wait_idle(100, ok);
    n_tests++; if (f_len.size() !== 1 || frame_errs(0, 64, 32'd0) !== 0) begin n_fail++; $display("FAIL areset_restart: frames %0d want 1 with seq 0", f_len.size()); end
    n_tests++; if (frame_cnt !== 32'd1 || mon_err !== 0) begin n_fail++; $display("FAIL areset_restart_cnt: cnt %0d proto_err %0d want 1 0", frame_cnt, mon_err); end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    frame_len = 11'd64; ifg_len = 16'd0;
    @(negedge clk);
    force dut.frame_cnt_q = 32'hFFFF_FFFF;
    pulse_start();
    repeat (2) @(negedge clk);
    release dut.frame_cnt_q;
    wait_frames(1, 200, ok);
    wait_idle(100, ok);
    n_tests++; if (f_len.size() !== 1 || frame_errs(0, 64, 32'hFFFF_FFFF) !== 0) begin n_fail++; $display("FAIL wrap_frame: frames %0d want 1 with seq ffffffff", f_len.size()); end
    if (f_len.size() >= 1) begin
      n_tests++; if ({mb[f_start[0]+14], mb[f_start[0]+15], mb[f_start[0]+16], mb[f_start[0]+17]} !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_seq: got %h%h%h%h want ffffffff", mb[f_start[0]+14], mb[f_start[0]+15], mb[f_start[0]+16], mb[f_start[0]+17]); end
    end
    n_tests++; if (frame_cnt !== 32'd0) begin n_fail++; $display("FAIL wrap_cnt: got %h want 0", frame_cnt); end
    pulse_start();
    wait_frames(2, 200, ok);
    wait_idle(100, ok);
    n_tests++; if (f_len.size() !== 2 || frame_errs(1, 64, 32'd0) !== 0) begin n_fail++; $display("FAIL wrap_next: frames %0d want 2 with seq 0", f_len.size()); end
    n_tests++; if (frame_cnt !== 32'd1 || mon_err !== 0) begin n_fail++; $display("FAIL wrap_next_cnt: cnt %0d proto_err %0d want 1 0", frame_cnt, mon_err); end
  endtask

  task automatic test_random();
    bit ok;
    int fl[6];
    int ig[6];
    do_reset();
    for (int i = 0; i < 6; i++) begin
      fl[i] = int'($urandom_range(40, 220));
      ig[i] = int'($urandom_range(0, 40));
    end
    frame_len = 11'(fl[0]); ifg_len = 16'(ig[0]); cont_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_sofs(i + 1, 1000, ok);
      if (i < 5) begin frame_len = 11'(fl[i+1]); ifg_len = 16'(ig[i+1]); end
      else cont_en = 1'b0;
    end
    wait_frames(6, 1000, ok);
    wait_idle(200, ok);
    n_tests++; if (f_len.size() !== 6) begin n_fail++; $display("FAIL rand_frames: got %0d want 6", f_len.size()); end
    for (int i = 0; i < f_len.size() && i < 6; i++) begin
      n_tests++; if (f_len[i] !== exp_len(fl[i]) || frame_errs(i, exp_len(fl[i]), 32'(i)) !== 0) begin n_fail++; $display("FAIL rand_frame%0d: len %0d want %0d, bad %0d", i, f_len[i], exp_len(fl[i]), frame_errs(i, exp_len(fl[i]), 32'(i))); end
      if (i > 0) begin
        n_tests++; if (f_sof[i] - f_eof[i-1] - 1 !== exp_gap(ig[i-1])) begin n_fail++; $display("FAIL rand_gap%0d: got %0d want %0d", i, f_sof[i] - f_eof[i-1] - 1, exp_gap(ig[i-1])); end
      end
    end
    if (f_len.size() == 6) begin
      n_tests++; if (busy_fall !== f_eof[5] + exp_gap(ig[5]) + 1) begin n_fail++; $display("FAIL rand_last_gap: busy fell %0d want %0d", busy_fall, f_eof[5] + exp_gap(ig[5]) + 1); end
    end
    n_tests++; if (frame_cnt !== 32'd6 || mon_err !== 0 || done_cyc.size() !== 6) begin n_fail++; $display("FAIL rand_cnt: cnt %0d proto_err %0d dones %0d want 6 0 6", frame_cnt, mon_err, done_cyc.size()); end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    areset_n = 1'b0; start = 1'b0; cont_en = 1'b0;
    frame_len = 11'd64; ifg_len = 16'd0;
    test_reset();
    test_single();
    test_cont();
    test_clamp();
    test_start_ignored();
    test_async_reset();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_tx_framegen.md
Name: mac_tx_framegen

Overview:
- Test-frame transmitter driving the logic-side TX byte stream (data/valid/sof/eof) of an RGMII MAC. It is the source-side counterpart of the MAC RX stream.
- Emits Ethernet frames with a fixed header, a 32-bit sequence number and a deterministic payload, so a far-end RX checker can verify every byte.
- The MAC adds preamble/SFD and FCS. This block emits only destination MAC through the last payload byte.

Parameters:
- DST_MAC, 48'hFFFF_FFFF_FFFF, destination address, sent MSB byte first
- SRC_MAC, 48'h0200_0000_0001, source address, sent MSB byte first
- ETHERTYPE, 16'h88B5, EtherType field
- MIN_IFG, 12, minimum idle cycles between frames (valid low)

Ports:
- mac_tx_clk  in  1  byte clock (125 MHz GTX clock domain)
- areset_n  in  1  asynchronous active-low reset
- start  in  1  single-shot request, one frame, honoured only in IDLE
- cont_en  in  1  continuous mode, back-to-back frames while high
- frame_len  in  11  frame length in bytes excluding FCS, sampled at frame start
- ifg_len  in  16  inter-frame gap in cycles, sampled at frame start
- mac_tx_data  out  8  frame byte
- mac_tx_valid  out  1  byte valid
- mac_tx_sof  out  1  first byte of frame
- mac_tx_eof  out  1  last byte of frame
- busy  out  1  high in FRAME or GAP
- frame_done  out  1  one-cycle pulse, cycle after the eof byte
- frame_cnt  out  32  frames completed, wraps at 2^32

Behaviour:
- Reset (async assert, sync release): state IDLE. mac_tx_data=0, mac_tx_valid=0, mac_tx_sof=0, mac_tx_eof=0, busy=0, frame_done=0, frame_cnt=0. All outputs are registered.
- States: IDLE, FRAME, GAP.
- IDLE -> FRAME when start=1 or cont_en=1. First byte is valid on the following cycle (latency 1).
  - Latch L = clamp(frame_len, 60, 1514).
  - Latch G = max(ifg_len, MIN_IFG).
  - Latch seq = frame_cnt.
- FRAME: one byte per cycle with valid held high continuously, no bubbles. Byte index k runs 0..L-1.
  - k 0-5: DST_MAC[47:0], MSB byte first.
  - k 6-11: SRC_MAC, MSB byte first.
  - k 12-13: ETHERTYPE, MSB first.
  - k 14-17: seq, big-endian.
  - k >= 18: (seq[7:0] + (k-18)) mod 256.
- sof=1 only at k=0. eof=1 only at k=L-1. sof and eof are never high together, since L >= 60.
- FRAME -> GAP after the eof byte. In the same edge, frame_cnt increments and frame_done pulses for exactly 1 cycle.
- GAP: valid=0, data=0, and valid stays low for exactly G cycles.
  - After G cycles, go to FRAME if cont_en=1; the next sof follows the last gap cycle with no extra idle cycle.
  - Otherwise go to IDLE.
- start in GAP or FRAME is ignored and not queued. start and cont_en together in IDLE start one frame, after which cont_en governs.
- cont_en falling mid-frame: the current frame completes, then the full gap runs, then IDLE.
- frame_len, ifg_len changes mid-frame do not affect the current frame or its gap.
- areset_n low mid-frame: valid, sof and eof drop immediately. There is no eof for the truncated frame and frame_cnt is cleared.
- Counter widths:
  - Byte counter: 11 bits.
  - Gap counter: 16 bits.
  - ifg_len=0 behaves as MIN_IFG.
  - frame_cnt wrap FFFF_FFFF -> 0 is legal, and seq follows the wrap.

Test Plan:
- Reset, then start pulse, frame_len=64, ifg_len=0 -> exactly 64 valid bytes. First bytes FF FF FF FF FF FF 02 00 00 00 00 01 88 B5 00 00 00 00. Payload bytes are 00..2D. sof at byte 0, eof at byte 63. frame_done 1 cycle later. frame_cnt=1. valid low for 12 cycles, then IDLE.
- cont_en=1, frame_len=100, ifg_len=20 for 3 frames -> each frame 100 bytes with no valid gaps. Exactly 20 low cycles between eof and the next sof. seq fields 0, 1, 2. Payload of frame 2 starts at 02.
- Clamping: frame_len=10 gives 60 bytes. frame_len=2000 gives 1514 bytes, with the last payload byte (seq[7:0]+1495) mod 256.
- start pulsed during FRAME and during GAP, cont_en=0 -> only 1 frame is emitted and frame_cnt=1.
- areset_n asserted at byte 30 of a 64-byte frame -> valid=0 asynchronously, no eof, frame_cnt=0. After release with cont_en=1, a new frame starts with seq=0.
- frame_cnt preloaded via force to FFFF_FFFF, start -> seq bytes FF FF FF FF. frame_cnt becomes 0 and the next frame has seq 00 00 00 00.
